// File: rtl/read_rd_lane_fetch_if.sv
// Bundles the RD lane-fetch signals: request (start/base/count/lane),
// SRAM read port, output stream and status.
//   start, base_addr, num_words, fmap_idx : request, sampled only while idle
//   sram_rd_en, sram_raddr, sram_rdata    : SRAM read port, data one cycle after rd_en
//   out_valid, out_ready, out_act, out_last: extracted-activation stream
//   busy, done                            : status
// Modports: slave = the fetch block, master = the requester/SRAM/consumer side.
interface read_rd_lane_fetch_if #(
  parameter int unsigned CH_NUM       = 24,
  parameter int unsigned ACT_PER_ADDR = 4,
  parameter int unsigned BW_PER_ACT   = 16,
  parameter int unsigned ADDR_BW      = 10,
  parameter int unsigned CNT_BW       = 10
);
  localparam int unsigned WORD_BW = CH_NUM * ACT_PER_ADDR * BW_PER_ACT;
  localparam int unsigned IDX_BW  = 7;

  logic                  start;
  logic [ADDR_BW-1:0]    base_addr;
  logic [CNT_BW-1:0]     num_words;
  logic [IDX_BW-1:0]     fmap_idx;
  logic                  sram_rd_en;
  logic [ADDR_BW-1:0]    sram_raddr;
  logic [WORD_BW-1:0]    sram_rdata;
  logic                  out_valid;
  logic                  out_ready;
  logic [BW_PER_ACT-1:0] out_act;
  logic                  out_last;
  logic                  busy;
  logic                  done;

  modport slave (
    input  start, base_addr, num_words, fmap_idx, sram_rdata, out_ready,
    output sram_rd_en, sram_raddr, out_valid, out_act, out_last, busy, done
  );

  modport master (
    output start, base_addr, num_words, fmap_idx, sram_rdata, out_ready,
    input  sram_rd_en, sram_raddr, out_valid, out_act, out_last, busy, done
  );
endinterface

// File: rtl/read_rd_lane_fetch.sv
// Streams num_words RD SRAM words starting at base_addr and extracts from each
// the single activation lane (slot ACT_PER_ADDR*fmap_idx + ACT_PER_ADDR-1 from
// the MSB) that the write side enables. Output is valid/ready, fed by an output
// register plus a 2-entry skid buffer that absorbs the SRAM read pipeline.
// Ports: clk, rst_n (async active-low), bus (read_rd_lane_fetch_if.slave).
// Build option: define RD_FETCH_RELU_EN to clamp negative lane values to 0 at
// capture; undefined passes the raw lane value.
module read_rd_lane_fetch #(
  parameter int unsigned CH_NUM       = 24,
  parameter int unsigned ACT_PER_ADDR = 4,
  parameter int unsigned BW_PER_ACT   = 16,
  parameter int unsigned ADDR_BW      = 10,
  parameter int unsigned CNT_BW       = 10
) (
  input logic               clk,
  input logic               rst_n,
  read_rd_lane_fetch_if.slave bus
);
  localparam int unsigned WORD_BW = CH_NUM * ACT_PER_ADDR * BW_PER_ACT;
  localparam int unsigned SH_BW   = $clog2(WORD_BW);
  localparam int unsigned IDX_BW  = 7;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic                  last;
    logic [BW_PER_ACT-1:0] act;
  } ent_t;

  state_t              state_q;
  logic                rd_en_q;
  logic                rd_last_q;
  logic [ADDR_BW-1:0]  raddr_q;
  logic [ADDR_BW-1:0]  next_addr_q;
  logic [CNT_BW-1:0]   remaining_q;
  logic [SH_BW-1:0]    lane_lo_q;
  logic                busy_q;
  logic                done_q;

  // rv_q marks the cycle in which SRAM data for an issued read is on sram_rdata
  logic                rv_q;
  logic                rv_last_q;

  ent_t                head_q;
  logic                head_vld_q;
  ent_t                skid_q [2];
  logic [1:0]          skid_cnt_q;

  logic                pop_c;
  logic                head_free_c;
  logic [2:0]          occ_c;
  logic                issue_ok_c;
  logic [IDX_BW-1:0]   idx_c;
  logic [SH_BW-1:0]    lane_lo_c;
  logic [BW_PER_ACT-1:0] lane_raw_c;
  ent_t                cap_c;
  ent_t                head_n;
  logic                head_vld_n;
  ent_t                skid_n [2];
  logic [1:0]          skid_cnt_n;

  // Issue credit: reads in flight plus skid entries must fit the skid buffer,
  // plus the output register when it is empty or being drained this cycle.
  assign pop_c       = head_vld_q & bus.out_ready;
  assign head_free_c = ~head_vld_q | bus.out_ready;
  assign occ_c       = 3'(skid_cnt_q) + 3'(rd_en_q) + 3'(rv_q);
  assign issue_ok_c  = occ_c < (3'd2 + 3'(head_free_c));

  // Out-of-range lane selectors fall back to lane 0; convert to an LSB offset
  assign idx_c     = (32'(bus.fmap_idx) >= CH_NUM) ? '0 : bus.fmap_idx;
  assign lane_lo_c = SH_BW'(ACT_PER_ADDR * (CH_NUM - 1 - 32'(idx_c)) * BW_PER_ACT);

  // Lane extraction at capture
  always_comb begin
    lane_raw_c = bus.sram_rdata[lane_lo_q +: BW_PER_ACT];
`ifdef RD_FETCH_RELU_EN
    cap_c.act  = lane_raw_c[BW_PER_ACT-1] ? '0 : lane_raw_c;
`else
    cap_c.act  = lane_raw_c;
`endif
    cap_c.last = rv_last_q;
  end

  // Output register / skid buffer next state; oldest skid entry is index 0
  always_comb begin
    head_n     = head_q;
    head_vld_n = head_vld_q;
    skid_n     = skid_q;
    skid_cnt_n = skid_cnt_q;
    if (head_free_c) begin
      if (skid_cnt_q != 2'd0) begin
        head_n     = skid_q[0];
        head_vld_n = 1'b1;
        skid_n[0]  = skid_q[1];
        skid_cnt_n = skid_cnt_q - 2'd1;
      end else if (rv_q) begin
        head_n     = cap_c;
        head_vld_n = 1'b1;
      end else begin
        head_vld_n = 1'b0;
      end
    end
    if (rv_q && !(head_free_c && (skid_cnt_q == 2'd0))) begin
      skid_n[skid_cnt_n[0]] = cap_c;
      skid_cnt_n            = skid_cnt_n + 2'd1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rv_q       <= 1'b0;
      rv_last_q  <= 1'b0;
      head_q     <= '0;
      head_vld_q <= 1'b0;
      skid_q     <= '{default: '0};
      skid_cnt_q <= 2'd0;
    end else begin
      rv_q       <= rd_en_q;
      rv_last_q  <= rd_last_q;
      head_q     <= head_n;
      head_vld_q <= head_vld_n;
      skid_q     <= skid_n;
      skid_cnt_q <= skid_cnt_n;
    end
  end

  // Control FSM with registered SRAM port and status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rd_en_q     <= 1'b0;
      rd_last_q   <= 1'b0;
      raddr_q     <= '0;
      next_addr_q <= '0;
      remaining_q <= '0;
      lane_lo_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_last_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.num_words == '0) begin
              done_q <= 1'b1;
            end else begin
              // The first read issues directly from the start edge
              rd_en_q     <= 1'b1;
              raddr_q     <= bus.base_addr;
              next_addr_q <= bus.base_addr + ADDR_BW'(1);
              remaining_q <= bus.num_words - CNT_BW'(1);
              lane_lo_q   <= lane_lo_c;
              busy_q      <= 1'b1;
              if (bus.num_words == CNT_BW'(1)) begin
                rd_last_q <= 1'b1;
                state_q   <= DRAIN;
              end else begin
                state_q   <= RUN;
              end
            end
          end
        end
        RUN: begin
          if (issue_ok_c) begin
            rd_en_q     <= 1'b1;
            raddr_q     <= next_addr_q;
            next_addr_q <= next_addr_q + ADDR_BW'(1);
            remaining_q <= remaining_q - CNT_BW'(1);
            if (remaining_q == CNT_BW'(1)) begin
              rd_last_q <= 1'b1;
              state_q   <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Finish on the handshake of the final entry with nothing else pending
          if (!rd_en_q && !rv_q && (skid_cnt_q == 2'd0) && pop_c && head_q.last) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.sram_rd_en = rd_en_q;
  assign bus.sram_raddr = raddr_q;
  assign bus.out_valid  = head_vld_q;
  assign bus.out_act    = head_q.act;
  assign bus.out_last   = head_q.last;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_read_rd_lane_fetch.sv
// Directed bench for read_rd_lane_fetch: reset values, latency, lane select,
// backpressure ordering/stability, zero length, ignored start, address wrap,
// mid-operation reset and the optional clamp.
module tb_read_rd_lane_fetch;
  localparam int unsigned CH_NUM       = 24;
  localparam int unsigned ACT_PER_ADDR = 4;
  localparam int unsigned BW_PER_ACT   = 16;
  localparam int unsigned ADDR_BW      = 10;
  localparam int unsigned CNT_BW       = 10;
  localparam int unsigned WORD_BW      = CH_NUM * ACT_PER_ADDR * BW_PER_ACT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  read_rd_lane_fetch_if #(
    .CH_NUM(CH_NUM), .ACT_PER_ADDR(ACT_PER_ADDR), .BW_PER_ACT(BW_PER_ACT),
    .ADDR_BW(ADDR_BW), .CNT_BW(CNT_BW)
  ) bus ();

  read_rd_lane_fetch #(
    .CH_NUM(CH_NUM), .ACT_PER_ADDR(ACT_PER_ADDR), .BW_PER_ACT(BW_PER_ACT),
    .ADDR_BW(ADDR_BW), .CNT_BW(CNT_BW)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // SRAM model: one-cycle read latency
  logic [WORD_BW-1:0] mem [1024];
  always @(posedge clk) begin
    if (bus.sram_rd_en) bus.sram_rdata <= mem[bus.sram_raddr];
  end

  // out_ready: held high, or the 1,0,0 repeating pattern when bp_en is set
  logic       bp_en = 1'b0;
  int unsigned bp_cnt = 0;
  always @(negedge clk) begin
    bus.out_ready <= bp_en ? (bp_cnt % 3 == 0) : 1'b1;
    bp_cnt        <= bp_cnt + 1;
  end

  // Monitor: reads issued, handshakes, occupancy and hold stability
  logic [15:0] got_act [$];
  logic        got_last [$];
  logic [9:0]  got_addr [$];
  logic        clr = 1'b0;
  int unsigned n_reads = 0, n_acc = 0, max_occ = 0, hold_viol = 0;
  logic        hold_q = 1'b0;
  logic [16:0] hold_val = '0;

  always @(posedge clk) begin
    if (clr) begin
      got_act.delete();
      got_last.delete();
      got_addr.delete();
      n_reads   <= 0;
      n_acc     <= 0;
      max_occ   <= 0;
      hold_viol <= 0;
      hold_q    <= 1'b0;
    end else if (rst_n) begin
      if (bus.sram_rd_en) got_addr.push_back(bus.sram_raddr);
      if (bus.out_valid && bus.out_ready) begin
        got_act.push_back(bus.out_act);
        got_last.push_back(bus.out_last);
      end
      n_reads <= n_reads + 32'(bus.sram_rd_en);
      n_acc   <= n_acc + 32'(bus.out_valid && bus.out_ready);
      if ((n_reads + 32'(bus.sram_rd_en) - n_acc - 32'(bus.out_valid && bus.out_ready)) > max_occ)
        max_occ <= n_reads + 32'(bus.sram_rd_en) - n_acc - 32'(bus.out_valid && bus.out_ready);
      if (hold_q && (!bus.out_valid || ({bus.out_last, bus.out_act} != hold_val)))
        hold_viol <= hold_viol + 1;
      hold_q   <= bus.out_valid && !bus.out_ready;
      hold_val <= {bus.out_last, bus.out_act};
    end else begin
      hold_q <= 1'b0;
    end
  end

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_field(input logic [9:0] a, input int unsigned hi, input logic [15:0] v);
    mem[a][hi -: 16] = v;
  endtask

  task automatic clear_mon();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Returns at the negedge of the cycle after the sampling edge
  task automatic issue_start(input logic [9:0] base, input logic [9:0] n, input logic [6:0] idx);
    bus.start     = 1'b1;
    bus.base_addr = base;
    bus.num_words = n;
    bus.fmap_idx  = idx;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int unsigned budget);
    int unsigned k = 0;
    while (!bus.done && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, " done seen"}, 32'(bus.done), 32'd1);
    @(negedge clk);
  endtask

  function automatic logic [31:0] reset_vec();
    return 32'({bus.sram_rd_en, bus.sram_raddr, bus.out_valid, bus.out_act,
                bus.out_last, bus.busy, bus.done});
  endfunction

  logic [15:0] exp_basic [4] = '{16'h0105, 16'h0106, 16'h0107, 16'h0108};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.num_words = '0;
    bus.fmap_idx  = '0;
    for (int a = 0; a < 1024; a++) mem[a] = {96{16'hA5A5}};

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset outputs", reset_vec(), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic stream with exact latency
    for (int k = 0; k < 4; k++) set_field(10'(5 + k), 1487, 16'(16'h0105 + k));
    clear_mon();
    issue_start(10'd5, 10'd4, 7'd0);
    check("basic rd_en T+1", 32'(bus.sram_rd_en), 32'd1);
    check("basic raddr T+1", 32'(bus.sram_raddr), 32'd5);
    check("basic busy T+1", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("basic valid T+2", 32'(bus.out_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("basic valid", 32'(bus.out_valid), 32'd1);
      check("basic act", 32'(bus.out_act), 32'(exp_basic[k]));
      check("basic last", 32'(bus.out_last), (k == 3) ? 32'd1 : 32'd0);
      check("basic done early", 32'(bus.done), 32'd0);
    end
    @(negedge clk);
    check("basic done", 32'(bus.done), 32'd1);
    check("basic busy end", 32'(bus.busy), 32'd0);
    check("basic valid end", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("basic done pulse", 32'(bus.done), 32'd0);
    check("basic reads", 32'(got_addr.size()), 32'd4);
    for (int k = 0; k < 4; k++) check("basic addr", 32'(got_addr[k]), 32'(5 + k));

    // Lane select
    set_field(10'd20, 15, 16'hBEEF);
    clear_mon();
    issue_start(10'd20, 10'd1, 7'd23);
    wait_done("lane23", 20);
    check("lane23 act", 32'(got_act[0]), 32'h0000BEEF);
    check("lane23 last", 32'(got_last[0]), 32'd1);

    set_field(10'd30, 1487, 16'h1234);
    clear_mon();
    issue_start(10'd30, 10'd1, 7'd100);
    wait_done("lane100", 20);
    check("lane100 act", 32'(got_act[0]), 32'h00001234);

    set_field(10'd31, 1167, 16'h0C0D);
    clear_mon();
    issue_start(10'd31, 10'd1, 7'd5);
    wait_done("lane5", 20);
    check("lane5 act", 32'(got_act[0]), 32'h00000C0D);

    // Backpressure
    for (int k = 0; k < 6; k++) set_field(10'(100 + k), 1487, 16'(16'h0600 + k));
    clear_mon();
    bp_en = 1'b1;
    issue_start(10'd100, 10'd6, 7'd0);
    wait_done("bp", 200);
    bp_en = 1'b0;
    check("bp count", 32'(got_act.size()), 32'd6);
    for (int k = 0; k < 6; k++) begin
      check("bp act", 32'(got_act[k]), 32'(16'h0600 + k));
      check("bp last", 32'(got_last[k]), (k == 5) ? 32'd1 : 32'd0);
    end
    check("bp occupancy<=3", 32'(max_occ <= 3), 32'd1);
    check("bp hold stable", hold_viol, 32'd0);

    // Zero length
    clear_mon();
    issue_start(10'd7, 10'd0, 7'd0);
    check("zero done T+1", 32'(bus.done), 32'd1);
    check("zero busy", 32'(bus.busy), 32'd0);
    check("zero rd_en", 32'(bus.sram_rd_en), 32'd0);
    @(negedge clk);
    check("zero done pulse", 32'(bus.done), 32'd0);
    check("zero reads", 32'(got_addr.size()), 32'd0);

    // Start while busy is ignored
    for (int k = 0; k < 3; k++) set_field(10'(200 + k), 1487, 16'(16'h2000 + k));
    clear_mon();
    issue_start(10'd200, 10'd3, 7'd0);
    issue_start(10'd500, 10'd9, 7'd3);
    wait_done("ign", 40);
    repeat (3) @(negedge clk);
    check("ign reads", 32'(got_addr.size()), 32'd3);
    check("ign outs", 32'(got_act.size()), 32'd3);
    for (int k = 0; k < 3; k++) begin
      check("ign addr", 32'(got_addr[k]), 32'(200 + k));
      check("ign act", 32'(got_act[k]), 32'(16'h2000 + k));
    end

    // Address wrap
    set_field(10'd1022, 1487, 16'h03FE);
    set_field(10'd1023, 1487, 16'h03FF);
    set_field(10'd0, 1487, 16'h3000);
    clear_mon();
    issue_start(10'd1022, 10'd3, 7'd0);
    wait_done("wrap", 40);
    check("wrap addr0", 32'(got_addr[0]), 32'd1022);
    check("wrap addr1", 32'(got_addr[1]), 32'd1023);
    check("wrap addr2", 32'(got_addr[2]), 32'd0);
    check("wrap act2", 32'(got_act[2]), 32'h00003000);

    // Reset mid-operation, then a fresh request
    for (int k = 0; k < 8; k++) set_field(10'(40 + k), 1487, 16'(16'h4000 + k));
    clear_mon();
    issue_start(10'd40, 10'd8, 7'd0);
    for (int k = 0; k < 20 && got_act.size() < 2; k++) @(negedge clk);
    check("rst two outputs", 32'(got_act.size() >= 2), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst mid outputs", reset_vec(), 32'h0);
    repeat (2) @(negedge clk);
    check("rst held outputs", reset_vec(), 32'h0);
    rst_n = 1'b1;
    set_field(10'd50, 1487, 16'h5000);
    set_field(10'd51, 1487, 16'h5001);
    clear_mon();
    issue_start(10'd50, 10'd2, 7'd0);
    check("post rst raddr", 32'(bus.sram_raddr), 32'd50);
    wait_done("post rst", 40);
    check("post rst count", 32'(got_act.size()), 32'd2);
    check("post rst act0", 32'(got_act[0]), 32'h00005000);
    check("post rst act1", 32'(got_act[1]), 32'h00005001);
    check("post rst last0", 32'(got_last[0]), 32'd0);
    check("post rst last1", 32'(got_last[1]), 32'd1);

    // Sign handling of the extracted lane
    set_field(10'd60, 1487, 16'h8001);
    set_field(10'd61, 1487, 16'h7FFF);
    clear_mon();
    issue_start(10'd60, 10'd2, 7'd0);
    wait_done("sign", 40);
`ifdef RD_FETCH_RELU_EN
    check("relu neg", 32'(got_act[0]), 32'h00000000);
`else
    check("raw neg", 32'(got_act[0]), 32'h00008001);
`endif
    check("pos passthrough", 32'(got_act[1]), 32'h00007FFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
